// File: rtl/opl3_sample_fetch_if.sv
// rtl/opl3_sample_fetch_if.sv - sequencer handshake and output sample bus for opl3_sample_fetch
//
// Purpose: bundles the sequencer sample handshake (ready/rd/A/B) and the
// show-ahead output sample stream (out_valid/out_l/out_r/out_ack).
// Signals:
//   ready      sequencer has a finished sample on A/B and is idle
//   rd         one-cycle pulse starting the next sequencer pass
//   A, B       signed left/right sample from the sequencer
//   out_valid  output FIFO head is valid
//   out_l/r    output FIFO head, left/right
//   out_ack    pop the output FIFO head
// Modports:
//   master  fetch block side (drives rd and the output stream)
//   slave   sequencer / audio sink side
interface opl3_sample_fetch_if;
  logic        ready;
  logic        rd;
  logic [15:0] A;
  logic [15:0] B;
  logic        out_valid;
  logic [15:0] out_l;
  logic [15:0] out_r;
  logic        out_ack;

  modport master (
    input  ready, A, B, out_ack,
    output rd, out_valid, out_l, out_r
  );

  modport slave (
    output ready, A, B, out_ack,
    input  rd, out_valid, out_l, out_r
  );
endinterface

// File: rtl/opl3_sample_fetch.sv
// rtl/opl3_sample_fetch.sv - OPL3 sample-rate strobe, sample fetch FSM and output FIFO
//
// Purpose: derives the output sample-rate strobe from clk with a fractional
// phase accumulator, fetches one stereo sample from the sequencer per strobe
// (restarting the sequencer with rd), queues the samples in a small
// show-ahead FIFO and reports timing/flow faults through sticky flags.
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   en         rate generator enable
//   bus        opl3_sample_fetch_if.master: ready/rd/A/B and out_* stream
//   flag_clr   clears all sticky flags (a same-cycle set wins)
//   late_err   sticky: strobe arrived while a fetch was outstanding
//   ovf_err    sticky: sample dropped because the FIFO was full
//   udf_err    sticky: out_ack while the FIFO was empty
module opl3_sample_fetch #(
  parameter int CLK_HZ     = 50000000,
  parameter int RATE_HZ    = 44100,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  opl3_sample_fetch_if.master        bus,
  input  logic                       flag_clr,
  output logic                       late_err,
  output logic                       ovf_err,
  output logic                       udf_err
);

  localparam logic [31:0] CLK_INC  = 32'(CLK_HZ);
  localparam logic [31:0] RATE_INC = 32'(RATE_HZ);
  localparam int          DEPTH    = 1 << DEPTH_LOG2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;

  // ---------------------------------------------------------------------
  // Rate generator. CLK_HZ < 2^31 keeps acc + RATE_HZ inside 32 bits.
  // ---------------------------------------------------------------------
  logic [31:0] acc;
  logic [31:0] acc_sum;
  logic        tick;

  assign acc_sum = acc + RATE_INC;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc  <= 32'd0;
      tick <= 1'b0;
    end else if (en) begin
      if (acc_sum >= CLK_INC) begin
        acc  <= acc_sum - CLK_INC;
        tick <= 1'b1;
      end else begin
        acc  <= acc_sum;
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Fetch FSM. rd is registered from (WAIT && ready), so it is high exactly
  // in the ISSUE cycle; the sequencer keeps ready high until it sees rd.
  // ---------------------------------------------------------------------
  logic [1:0]  state;
  logic [31:0] pair;
  logic        rd_q;
  logic        push;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      pair  <= 32'd0;
      rd_q  <= 1'b0;
    end else begin
      rd_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tick) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.ready) begin
            pair  <= {bus.A, bus.B};
            rd_q  <= 1'b1;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.rd = rd_q;
  assign push   = (state == ST_ISSUE);

  // ---------------------------------------------------------------------
  // Show-ahead FIFO. Pointers carry one extra wrap bit to tell full from
  // empty. The head is a register so it can hold its last value (and read
  // as zero after reset) while the FIFO is empty.
  // ---------------------------------------------------------------------
  logic [31:0]         mem [DEPTH];
  logic [DEPTH_LOG2:0] wp;
  logic [DEPTH_LOG2:0] rp;
  logic [DEPTH_LOG2:0] wp_n;
  logic [DEPTH_LOG2:0] rp_n;
  logic                fifo_empty;
  logic                fifo_full;
  logic                pop;
  logic                push_ok;
  logic [31:0]         head;
  logic                valid_q;

  assign fifo_empty = (wp == rp);
  assign fifo_full  = (wp[DEPTH_LOG2] != rp[DEPTH_LOG2]) &&
                      (wp[DEPTH_LOG2-1:0] == rp[DEPTH_LOG2-1:0]);
  assign pop        = bus.out_ack && !fifo_empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign push_ok    = push && (!fifo_full || pop);
  assign wp_n       = wp + {{DEPTH_LOG2{1'b0}}, push_ok};
  assign rp_n       = rp + {{DEPTH_LOG2{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp[DEPTH_LOG2-1:0]] <= pair;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp      <= '0;
      rp      <= '0;
      valid_q <= 1'b0;
      head    <= 32'd0;
    end else begin
      wp      <= wp_n;
      rp      <= rp_n;
      valid_q <= (wp_n != rp_n);
      if (wp_n != rp_n) begin
        // New head is the entry being written this cycle when the read
        // pointer lands on the write slot, otherwise already in memory.
        head <= (rp_n == wp) ? pair : mem[rp_n[DEPTH_LOG2-1:0]];
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_l     = head[31:16];
  assign bus.out_r     = head[15:0];

  // ---------------------------------------------------------------------
  // Sticky flags; a set in the same cycle as flag_clr wins.
  // ---------------------------------------------------------------------
  logic late_set;
  logic ovf_set;
  logic udf_set;

  assign late_set = tick && (state != ST_IDLE);
  assign ovf_set  = push && !push_ok;
  assign udf_set  = bus.out_ack && fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      late_err <= 1'b0;
      ovf_err  <= 1'b0;
      udf_err  <= 1'b0;
    end else begin
      late_err <= late_set | (late_err & ~flag_clr);
      ovf_err  <= ovf_set  | (ovf_err  & ~flag_clr);
      udf_err  <= udf_set  | (udf_err  & ~flag_clr);
    end
  end

endmodule

// File: tb/tb_opl3_sample_fetch.sv
// tb/tb_opl3_sample_fetch.sv - directed self-checking bench for opl3_sample_fetch
module tb_opl3_sample_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  logic rst_a, en_a, clr_a, late_a, ovf_a, udf_a;
  logic rst_b, en_b, clr_b, late_b, ovf_b, udf_b;

  opl3_sample_fetch_if ifa ();
  opl3_sample_fetch_if ifb ();

  // Instance A only exercises the rate generator: the sink pops whatever shows up.
  assign ifa.out_ack = ifa.out_valid;

  opl3_sample_fetch #(.CLK_HZ(7), .RATE_HZ(2), .DEPTH_LOG2(2)) u_dut_a (
    .clk      (clk),
    .reset    (rst_a),
    .en       (en_a),
    .bus      (ifa.master),
    .flag_clr (clr_a),
    .late_err (late_a),
    .ovf_err  (ovf_a),
    .udf_err  (udf_a)
  );

  opl3_sample_fetch #(.CLK_HZ(10), .RATE_HZ(1), .DEPTH_LOG2(2)) u_dut_b (
    .clk      (clk),
    .reset    (rst_b),
    .en       (en_b),
    .bus      (ifb.master),
    .flag_clr (clr_b),
    .late_err (late_b),
    .ovf_err  (ovf_b),
    .udf_err  (udf_b)
  );

  // rd may only follow a cycle in which ready was high.
  int   rd_viol = 0;
  logic prev_ready_a = 1'b0;
  logic prev_ready_b = 1'b0;
  always @(negedge clk) begin
    if (ifa.rd === 1'b1 && !prev_ready_a) rd_viol++;
    if (ifb.rd === 1'b1 && !prev_ready_b) rd_viol++;
    prev_ready_a = ifa.ready;
    prev_ready_b = ifb.ready;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rd_b(input int max_cyc, output int at);
    int n;
    step();
    n = 1;
    while (ifb.rd !== 1'b1 && n < max_cyc) begin
      step();
      n++;
    end
    at = cyc;
    check("rd_seen", ifb.rd, 1'b1);
  endtask

  int c0, t, nrd, first_rd, rd200, prev_rd, prev_int, bad_int, rel, rd_seen;

  initial begin
    rst_a = 1'b1; en_a = 1'b1; clr_a = 1'b0;
    rst_b = 1'b1; en_b = 1'b1; clr_b = 1'b0;
    ifa.ready = 1'b1; ifa.A = 16'h0000; ifa.B = 16'h0000;
    ifb.ready = 1'b0; ifb.A = 16'h0000; ifb.B = 16'h0000; ifb.out_ack = 1'b0;
    step(); step(); step();

    // Reset state
    check("rst_rd",    ifb.rd, 0);
    check("rst_valid", ifb.out_valid, 0);
    check("rst_out_l", ifb.out_l, 0);
    check("rst_out_r", ifb.out_r, 0);
    check("rst_flags", {late_b, ovf_b, udf_b}, 0);

    // Rate generator 7/2: rd = tick + 2, ticks at 4,7,11,14,...; 200th tick at 700
    rst_a = 1'b0;
    c0 = cyc; nrd = 0; first_rd = -1; rd200 = -1; prev_rd = -1; prev_int = -1; bad_int = 0;
    for (int i = 0; i <= 705; i++) begin
      if (ifa.rd === 1'b1) begin
        nrd++;
        rel = cyc - c0;
        if (nrd == 1) first_rd = rel;
        if (nrd == 200) rd200 = rel;
        if (prev_rd >= 0) begin
          if ((rel - prev_rd) != 3 && (rel - prev_rd) != 4) bad_int++;
          if (prev_int == (rel - prev_rd)) bad_int++;
          prev_int = rel - prev_rd;
        end
        prev_rd = rel;
      end
      step();
    end
    check("rate_first_rd", first_rd, 6);
    check("rate_rd200",    rd200, 702);
    check("rate_count",    nrd, 200);
    check("rate_interval", bad_int, 0);
    check("rate_flags",    {late_a, ovf_a, udf_a}, 0);

    // Latency: tick at 10 after reset release, rd at 12, valid at 13
    ifb.ready = 1'b1; ifb.A = 16'h1234; ifb.B = 16'hFEDC;
    rst_b = 1'b0;
    c0 = cyc;
    wait_rd_b(20, t);
    check("lat_rd_cycle", t - c0, 12);
    check("lat_valid_at_rd", ifb.out_valid, 0);
    step();
    check("lat_rd_one_cycle", ifb.rd, 0);
    check("lat_valid", ifb.out_valid, 1);
    check("lat_out_l", ifb.out_l, 16'h1234);
    check("lat_out_r", ifb.out_r, 16'hFEDC);
    ifb.out_ack = 1'b1;
    step();
    ifb.out_ack = 1'b0;
    check("pop_empty", ifb.out_valid, 0);
    check("pop_hold_l", ifb.out_l, 16'h1234);
    check("pop_no_udf", udf_b, 0);

    // Late synthesis: ready low from cycle 14 to 40, ticks at 30/40 arrive in WAIT
    ifb.ready = 1'b0; ifb.A = 16'h5555; ifb.B = 16'hAAAA;
    rd_seen = 0;
    for (int i = 0; i < 27; i++) begin
      step();
      if (ifb.rd === 1'b1) rd_seen++;
    end
    check("late_no_rd", rd_seen, 0);
    check("late_set", late_b, 1);
    ifb.ready = 1'b1;
    step();
    check("late_rd", ifb.rd, 1);
    step();
    check("late_valid", ifb.out_valid, 1);
    check("late_out_l", ifb.out_l, 16'h5555);
    check("late_out_r", ifb.out_r, 16'hAAAA);
    ifb.out_ack = 1'b1;
    step();
    ifb.out_ack = 1'b0;
    check("late_single", ifb.out_valid, 0);
    clr_b = 1'b1;
    step();
    clr_b = 1'b0;
    check("late_clr", late_b, 0);

    // Overflow: six fetches, no pops; samples 5 and 6 are dropped
    for (int k = 1; k <= 6; k++) begin
      ifb.A = 16'(k); ifb.B = 16'hB000 + 16'(k);
      wait_rd_b(15, t);
    end
    ifb.A = 16'd7; ifb.B = 16'hB007;
    step();
    check("ovf_set", ovf_b, 1);
    check("ovf_valid", ifb.out_valid, 1);
    ifb.out_ack = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("drain_l", ifb.out_l, k);
      check("drain_r", ifb.out_r, 32'hB000 + k);
      step();
    end
    check("drain_empty", ifb.out_valid, 0);
    check("drain_no_udf", udf_b, 0);
    step();
    check("udf_set", udf_b, 1);
    ifb.out_ack = 1'b0;

    // Full FIFO with a pop in the ISSUE cycle: push accepted
    clr_b = 1'b1;
    step();
    clr_b = 1'b0;
    check("clr_all", {late_b, ovf_b, udf_b}, 0);
    for (int k = 7; k <= 10; k++) begin
      ifb.A = 16'(k); ifb.B = 16'hB000 + 16'(k);
      wait_rd_b(15, t);
    end
    ifb.A = 16'd11; ifb.B = 16'hB00B;
    wait_rd_b(15, t);
    ifb.out_ack = 1'b1;
    step();
    ifb.out_ack = 1'b0;
    check("full_pop_no_ovf", ovf_b, 0);
    check("full_pop_head", ifb.out_l, 16'd8);
    // Overflow and flag_clr together: set wins
    ifb.A = 16'd12; ifb.B = 16'hB00C;
    wait_rd_b(15, t);
    clr_b = 1'b1;
    step();
    clr_b = 1'b0;
    check("set_wins", ovf_b, 1);
    ifb.out_ack = 1'b1;
    for (int k = 8; k <= 11; k++) begin
      check("full_drain_l", ifb.out_l, k);
      step();
    end
    ifb.out_ack = 1'b0;
    check("full_drain_empty", ifb.out_valid, 0);

    // Reset while in WAIT with 3 entries queued
    for (int k = 13; k <= 15; k++) begin
      ifb.A = 16'(k); ifb.B = 16'hB000 + 16'(k);
      wait_rd_b(15, t);
    end
    ifb.ready = 1'b0;
    for (int i = 0; i < 12; i++) step();
    check("pre_rst_valid", ifb.out_valid, 1);
    ifb.ready = 1'b1;
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    c0 = cyc;
    check("mid_rst_rd", ifb.rd, 0);
    check("mid_rst_valid", ifb.out_valid, 0);
    check("mid_rst_out_l", ifb.out_l, 0);
    check("mid_rst_flags", {late_b, ovf_b, udf_b}, 0);
    ifb.A = 16'h00EE; ifb.B = 16'h00DD;
    wait_rd_b(20, t);
    check("mid_rst_rd_cycle", t - c0, 12);
    step();
    check("mid_rst_out", {ifb.out_l, ifb.out_r}, 32'h00EE_00DD);

    check("rd_after_ready", rd_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/opl3_sample_fetch.md
# opl3_sample_fetch

Consumer side of the OPL3 sequencer's `ready`/`rd`/`A`/`B` sample handshake.
- Generates the output sample-rate strobe from `clk` with a fractional phase accumulator.
- Fetches one stereo sample per strobe and starts the next synthesis pass.
- Buffers samples in a small FIFO toward the audio output path (DAC/I2S serializer or mixer).
- Reports late-synthesis and FIFO overrun/underrun conditions through sticky flags.

## Interface
Parameters:
- `CLK_HZ`, 50000000, `clk` frequency; must be ≥ 2·`RATE_HZ`; must fit in 31 bits.
- `RATE_HZ`, 44100, output sample rate.
- `DEPTH_LOG2`, 2, FIFO depth is 2^`DEPTH_LOG2` stereo entries.

Ports:
- `clk`  in  1  single system clock; everything is synchronous to its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  rate generator enable; when low, accumulator holds and no strobes are generated.
- `ready`  in  1  sequencer has a finished sample on `A`/`B` and is idle.
- `A`  in  16  sequencer left sample, signed.
- `B`  in  16  sequencer right sample, signed.
- `rd`  out  1  one-cycle pulse that starts the next sequencer pass; asserted only while `ready`=1.
- `out_valid`  out  1  FIFO head is valid.
- `out_l`  out  16  FIFO head, left.
- `out_r`  out  16  FIFO head, right.
- `out_ack`  in  1  pop the FIFO head.
- `flag_clr`  in  1  clears all sticky flags.
- `late_err`  out  1  sticky; a strobe arrived while a fetch was still outstanding.
- `ovf_err`  out  1  sticky; a sample was dropped because the FIFO was full.
- `udf_err`  out  1  sticky; `out_ack` was asserted while `out_valid`=0.

## Operation
Rate generator:
- Uses a 32-bit unsigned accumulator `acc`.
- Each cycle with `en`=1: if `acc+RATE_HZ ≥ CLK_HZ`, then `acc ← acc+RATE_HZ−CLK_HZ` and a registered strobe `tick` is asserted for the next cycle. Otherwise `acc ← acc+RATE_HZ`.
- With `en`=0, `acc` holds its value and `tick`=0.

Fetch FSM has three states:
- IDLE: on `tick`, go to WAIT.
- WAIT: when `ready`=1, latch `{A,B}` and go to ISSUE. Otherwise stay in WAIT.
- ISSUE: `rd`=1 for this cycle only, push the latched pair into the FIFO, then go to IDLE.

Fetch FSM rules:
- A `tick` seen in WAIT or ISSUE is dropped and sets `late_err`.
- The captured pair is the result of the previous pass, so output lags synthesis by one sample period. The first pair after reset is the sequencer's power-up pass.
- `rd` is registered. It is never asserted unless `ready` was high in the preceding WAIT cycle. The sequencer holds `ready` until it samples `rd`, so `ready`=1 during the ISSUE cycle.

FIFO:
- 2^`DEPTH_LOG2` entries, 32 bits each (`{A,B}`), show-ahead. `out_l`/`out_r` are the head whenever `out_valid`=1.
- Pointers are `DEPTH_LOG2`+1 bits wide and wrap naturally.
- Full: ISSUE push is accepted if not full, or if a pop happens in the same cycle. Otherwise the sample is dropped and `ovf_err` is set.
- Empty: `out_ack` is ignored and `udf_err` is set. A push and `out_ack` in the same cycle on an empty FIFO: the push is accepted and the ack counts as underrun.
- `out_l`/`out_r` hold their last value when empty.

Flags:
- Set and clear in the same cycle: set wins.
- `flag_clr` does not affect the FIFO or the FSM.

## Timing
Reset values:
- `rd`=0, `out_valid`=0, `out_l`=`out_r`=0, all flags 0.
- `acc`=0, `tick`=0, FSM in IDLE, FIFO empty.

Reset mid-operation:
- Abandons any WAIT/ISSUE and empties the FIFO.
- `rd` is 0 in the cycle after `reset` is sampled.
- A pending sequencer pass is not affected.

Latency:
- `tick` in cycle T (FSM in IDLE) → WAIT in T+1.
- If `ready`=1 in T+1: `rd` and FIFO write in T+2; `out_valid`=1 in T+3 if the FIFO was empty.
- If `ready` is low, each extra cycle of low `ready` adds one cycle.

Pop: `out_ack` with `out_valid`=1 in cycle T presents the next head (or `out_valid`=0) in T+1.

## Test plan
- `CLK_HZ`=7, `RATE_HZ`=2, `en`=1 from reset: ticks occur with intervals 4,3,4,3 cycles, first tick in cycle 4 → exactly 2 ticks per 7 cycles, no drift over 700 cycles (200 ticks).
- Sequencer model holding `ready`=1 with `A`=16'h1234, `B`=16'hFEDC: tick at T → `rd` high only at T+2, then `out_valid` at T+3 with `out_l`=16'h1234, `out_r`=16'hFEDC.
- Hold `ready`=0 for 20 cycles after a tick, with `CLK_HZ`=10, `RATE_HZ`=1: the next tick sets `late_err` and is dropped, `rd` is not asserted until `ready` rises, and exactly one sample is pushed.
- `DEPTH_LOG2`=2, `out_ack`=0, 6 fetches with `A`=1..6 → `ovf_err`=1; draining yields 1,2,3,4, then `out_valid`=0; a further `out_ack` sets `udf_err`.
- Full FIFO with `out_ack`=1 in the same cycle as an ISSUE push → push accepted, `ovf_err` stays 0, FIFO remains full. `flag_clr` and a new overflow in the same cycle → flag stays 1.
- Assert `reset` one cycle while in WAIT with 3 entries queued → next cycle `out_valid`=0, `rd`=0, flags 0, and the next tick comes `CLK_HZ`/`RATE_HZ` cycles later.
